// File: rtl/s27_array.sv
// s27_array: LANES parallel s27 cores with sync reset, enable, full scan chain and optional G17->G0 lane chaining
// Ports: CK clock; RST sync active-high reset; EN functional enable; SE/SI/SO scan enable/in/out;
//        G0..G3 per-lane inputs; G17 per-lane combinational output; Q flat state, Q[3i+2:3i] = lane i {G7,G6,G5}
module s27_array #(
   parameter int         LANES     = 4,
   parameter bit         CHAIN     = 1'b0,
   parameter logic [2:0] RST_STATE = 3'b000
) (
   input  logic                 CK,
   input  logic                 RST,
   input  logic                 EN,
   input  logic                 SE,
   input  logic                 SI,
   output logic                 SO,
   input  logic [LANES-1:0]     G0,
   input  logic [LANES-1:0]     G1,
   input  logic [LANES-1:0]     G2,
   input  logic [LANES-1:0]     G3,
   output logic [LANES-1:0]     G17,
   output logic [3*LANES-1:0]   Q
);
   logic [3*LANES-1:0] q, nxt;
   for (genvar i = 0; i < LANES; i++) begin : lane
      logic g0e, g5, g6, g7, g8, g9, g10, g11, g12, g13, g14, g15, g16, g17;
      assign {g7, g6, g5} = q[3*i +: 3];
      // per-lane locals keep the ripple acyclic at signal level (lane i reads only lane i-1)
      if (CHAIN && i > 0) begin : ch
         assign g0e = lane[i-1].g17;
      end else begin : di
         assign g0e = G0[i];
      end
      assign g14 = ~g0e;
      assign g12 = ~(G1[i] | g7);
      assign g13 = ~(G2[i] | g12);
      assign g8  = g14 & g6;
      assign g15 = g12 | g8;
      assign g16 = G3[i] | g8;
      assign g9  = ~(g16 & g15);
      assign g11 = ~(g5 | g9);
      assign g10 = ~(g14 | g11);
      assign g17 = ~g11;
      assign G17[i] = g17;
      assign nxt[3*i +: 3] = {g13, g11, g10};
   end
   // scan enters at lane 0 G5 and leaves from the top lane's G7
   always_ff @(posedge CK)
      if (RST) q <= {LANES{RST_STATE}};
      else if (SE) q <= {q[3*LANES-2:0], SI};
      else if (EN) q <= nxt;
   assign Q  = q;
   assign SO = q[3*LANES-1];
endmodule
